// File: rtl/sine_dds_pkg.sv
// sine_dds_pkg: shared widths, quadrant type and phase fold for the DDS scheduler.
package sine_dds_pkg;
  localparam int ROM_AW = 9;
  localparam int ROM_DW = 16;
  localparam logic [ROM_DW-1:0] ROM_MAX = 16'hFFFF;
  localparam int QUAD_W = 2;
  localparam int FOLD_W = QUAD_W + ROM_AW;
  typedef enum logic [QUAD_W-1:0] {Q0, Q1, Q2, Q3} quad_e;
  typedef struct packed {
    quad_e             quad;
    logic [ROM_AW-1:0] adrs;
  } fold_t;
  // Odd quadrants walk the quarter-wave table backwards; 511-idx is ~idx.
  function automatic fold_t fold(input logic [FOLD_W-1:0] top);
    fold_t f;
    f.quad = quad_e'(top[FOLD_W-1 -: QUAD_W]);
    f.adrs = top[ROM_AW] ? ~top[ROM_AW-1:0] : top[ROM_AW-1:0];
    return f;
  endfunction
endpackage

// File: rtl/sine_fold_out.sv
// sine_fold_out: S1 magnitude capture with top-entry saturation, S2 sign and output registers.
module sine_fold_out
  import sine_dds_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue,
  input  logic [ROM_AW-1:0] rom_adrs,
  input  logic [ROM_DW-1:0] rom_data,
  input  quad_e             quad,
  input  logic [CH_W-1:0]   ch,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [ROM_DW:0]   sample_out,
  output logic              frame
);
  logic              v1_q, v1_d, v2_q, v2_d, frame_q, frame_d;
  logic [ROM_DW-1:0] mag_q, mag_d;
  quad_e             quad_q, quad_d;
  logic [CH_W-1:0]   ch1_q, ch1_d, ch2_q, ch2_d;
  logic [ROM_DW:0]   out_q, out_d;
  always_comb begin
    v1_d    = issue && !flush;
    mag_d   = (rom_adrs == '1) ? ROM_MAX : rom_data;
    quad_d  = quad;
    ch1_d   = ch;
    v2_d    = v1_q && !flush;
    ch2_d   = ch1_q;
    out_d   = (quad_q inside {Q2, Q3}) ? -{1'b0, mag_q} : {1'b0, mag_q};
    frame_d = v1_q && !flush && (ch1_q == CH_W'(NCH - 1));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q    <= 1'b0;
      mag_q   <= '0;
      quad_q  <= Q0;
      ch1_q   <= '0;
      v2_q    <= 1'b0;
      ch2_q   <= '0;
      out_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      mag_q   <= mag_d;
      quad_q  <= quad_d;
      ch1_q   <= ch1_d;
      v2_q    <= v2_d;
      ch2_q   <= ch2_d;
      out_q   <= out_d;
      frame_q <= frame_d;
    end
  assign sample_valid = v2_q;
  assign sample_ch    = ch2_q;
  assign sample_out   = out_q;
  assign frame        = frame_q;
endmodule

// File: rtl/sine_dds_sched.sv
// sine_dds_sched: round-robin multi-channel DDS sharing one quarter-wave sine ROM.
module sine_dds_sched
  import sine_dds_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               ftw_wr,
  input  logic [CH_W-1:0]    ftw_ch,
  input  logic [PHASE_W-1:0] ftw_data,
  output logic [ROM_AW-1:0]  rom_adrs,
  input  logic [ROM_DW-1:0]  rom_data,
  output logic               sample_valid,
  output logic [CH_W-1:0]    sample_ch,
  output logic [ROM_DW:0]    sample_out,
  output logic               frame
);
  logic [CH_W-1:0]                slot_q, slot_d;
  logic [NCH-1:0][PHASE_W-1:0]    phase_q, phase_d, ftw_q, ftw_d;
  fold_t                          f;
  assign f        = fold(phase_q[slot_q][PHASE_W-1 -: FOLD_W]);
  assign rom_adrs = f.adrs;
  // The accumulation reads ftw_q, so a same-cycle write lands one slot later.
  always_comb begin
    slot_d  = slot_q;
    phase_d = phase_q;
    ftw_d   = ftw_q;
    if (ftw_wr) ftw_d[ftw_ch] = ftw_data;
    if (phase_clr) begin
      slot_d  = '0;
      phase_d = '0;
    end else if (en) begin
      slot_d          = slot_q + 1'b1;
      phase_d[slot_q] = phase_q[slot_q] + ftw_q[slot_q];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q  <= '0;
      phase_q <= '0;
      ftw_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      phase_q <= phase_d;
      ftw_q   <= ftw_d;
    end
  sine_fold_out #(.NCH(NCH), .CH_W(CH_W)) u_out (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (phase_clr),
    .issue        (en),
    .rom_adrs     (rom_adrs),
    .rom_data     (rom_data),
    .quad         (f.quad),
    .ch           (slot_q),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_out   (sample_out),
    .frame        (frame)
  );
endmodule

// File: tb/tb_sine_dds_sched.sv
// tb_sine_dds_sched: directed stimulus with a reference model feeding a scoreboard queue.
module tb_sine_dds_sched;
  logic        clk = 0, rst_n = 0, en = 0, phase_clr = 0, ftw_wr = 0;
  logic [1:0]  ftw_ch = 0;
  logic [31:0] ftw_data = 0;
  logic [8:0]  rom_adrs;
  logic [15:0] rom_data;
  logic        sample_valid, frame;
  logic [1:0]  sample_ch;
  logic [16:0] sample_out;
  int total = 0, bad = 0, cnt = 0;
  typedef struct {int cyc; logic [16:0] v; logic [1:0] ch;} exp_t;
  exp_t sb[$];
  logic [31:0] m_ph[4], m_ftw[4];
  logic [1:0]  m_slot;

  sine_dds_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr), .ftw_wr(ftw_wr),
    .ftw_ch(ftw_ch), .ftw_data(ftw_data), .rom_adrs(rom_adrs), .rom_data(rom_data),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_out(sample_out), .frame(frame)
  );

  // Stand-in quarter-wave table: linear ramp, top entry aliased to 0 like a real 16-bit ROM.
  function automatic logic [15:0] rom(input logic [8:0] a);
    return (a == 9'h1FF) ? 16'd0 : {a[8:0], 7'b0};
  endfunction
  assign rom_data = rom(rom_adrs);

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cnt);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (sample_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'(sample_valid), 0);
      else begin
        e = sb.pop_front();
        chk("latency", cnt, e.cyc + 2);
        chk("sample_out", 32'(sample_out), 32'(e.v));
        chk("sample_ch", 32'(sample_ch), 32'(e.ch));
        chk("frame", 32'(frame), 32'(e.ch == 2'd3));
      end
    end else if (sb.size() > 0 && cnt > sb[0].cyc + 2) begin
      chk("missing_valid", 32'(sample_valid), 1);
      void'(sb.pop_front());
    end
  end

  task automatic model_reset(input bit clr_ftw);
    for (int i = 0; i < 4; i++) begin
      m_ph[i] = 0;
      if (clr_ftw) m_ftw[i] = 0;
    end
    m_slot = 0;
  endtask

  task automatic step(input bit e, input bit c, input bit w, input logic [1:0] wc, input logic [31:0] wd);
    logic [1:0]  q;
    logic [8:0]  a;
    logic [16:0] m;
    en = e; phase_clr = c; ftw_wr = w; ftw_ch = wc; ftw_data = wd;
    q = m_ph[m_slot][31:30];
    a = q[0] ? ~m_ph[m_slot][29:21] : m_ph[m_slot][29:21];
    chk("rom_adrs", 32'(rom_adrs), 32'(a));
    if (c) begin
      while (sb.size() > 0 && sb[$].cyc >= cnt - 1) void'(sb.pop_back());
      model_reset(0);
    end else if (e) begin
      m = (a == 9'h1FF) ? 17'd65535 : {1'b0, rom(a)};
      sb.push_back('{cnt, q[1] ? 17'd0 - m : m, m_slot});
      m_ph[m_slot] = m_ph[m_slot] + m_ftw[m_slot];
      m_slot = m_slot + 1'b1;
    end
    if (w) m_ftw[wc] = wd;
    @(negedge clk); #1;
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_out", 32'(sample_out), 0);
    chk("rst_ch", 32'(sample_ch), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_adrs", 32'(rom_adrs), 0);
  endtask

  initial begin
    model_reset(1);
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1;
    run(10, 1);
    step(0, 0, 1, 0, 32'h4000_0000);
    run(20, 1);
    step(0, 0, 1, 1, 32'h0020_0000);
    run(4400, 1);
    for (int i = 0; i < 4 && m_slot != 2; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 2, 32'h1000_0000);
    run(12, 1);
    run(5, 0);
    run(12, 1);
    step(1, 1, 1, 3, 32'h0800_0000);
    run(16, 1);
    rst_n = 0;
    #1;
    chk_reset_outputs();
    #1;
    rst_n = 1;
    sb.delete();
    model_reset(1);
    run(12, 1);
    run(4, 0);
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
